// File: rtl/i2c_gpio_expander_target_pkg.sv
// Shared constants for the TCA9555-compatible GPIO expander: bus address,
// register indices (identical to the TCA9555 command bytes), reset values and FSM encoding.
package i2c_gpio_expander_target_pkg;

    localparam logic [6:0] TCA9555_ADDR_BASE = 7'b0100_000;

    localparam logic [2:0] REG_IN0  = 3'd0;
    localparam logic [2:0] REG_IN1  = 3'd1;
    localparam logic [2:0] REG_OUT0 = 3'd2;
    localparam logic [2:0] REG_OUT1 = 3'd3;
    localparam logic [2:0] REG_POL0 = 3'd4;
    localparam logic [2:0] REG_POL1 = 3'd5;
    localparam logic [2:0] REG_CFG0 = 3'd6;
    localparam logic [2:0] REG_CFG1 = 3'd7;

    localparam logic [15:0] RST_OUT = 16'hFFFF;
    localparam logic [15:0] RST_POL = 16'h0000;
    localparam logic [15:0] RST_CFG = 16'hFFFF;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        CMD,
        CMD_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

    // Registers come in port0/port1 pairs; auto-increment flips between them.
    function automatic logic [2:0] pair_toggle(input logic [2:0] p);
        return {p[2:1], ~p[0]};
    endfunction

endpackage

// File: rtl/i2c_target_bit_ctrl.sv
// Bit-level I2C target front end: pad synchronizers, SCL edge and START/STOP
// detection, and the 8-bit receive shifter with its bit counter.
module i2c_target_bit_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_pad,
    input  logic       sda_pad,
    input  logic       clr,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start,
    output logic       stop,
    output logic       sda,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_s;
    logic                   scl_q;
    logic                   sda_q;
    logic [3:0]             bit_cnt;

    // Synchronizers carry no reset so leaving reset never fakes a bus edge.
    always_ff @(posedge clk) begin
        scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_pad};
        sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_pad};
        scl_q    <= scl_s;
        sda_q    <= sda;
    end

    assign scl_s     = scl_pipe[SYNC_STAGES-1];
    assign sda       = sda_pipe[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start     = scl_s & scl_q & sda_q & ~sda;
    assign stop      = scl_s & scl_q & ~sda_q & sda;
    assign byte_done = (bit_cnt == 4'd8);

    always_ff @(posedge clk) begin
        if (reset || start || clr) begin
            bit_cnt <= '0;
        end else if (scl_rise && !byte_done) begin
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (scl_rise && !byte_done) begin
            rx_byte <= {rx_byte[6:0], sda};
        end
    end

endmodule

// File: rtl/i2c_gpio_expander_target.sv
// TCA9555-style 16-bit I2C GPIO expander target: protocol FSM, register file
// and input-change interrupt on top of the bit-level front end.
module i2c_gpio_expander_target
    import i2c_gpio_expander_target_pkg::*;
#(
    parameter logic [6:0] SADR        = TCA9555_ADDR_BASE,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_scl,
    input  logic        i_sda,
    output logic        o_sda_oe,
    input  logic [15:0] i_gpio_in,
    output logic [15:0] o_gpio_out,
    output logic [15:0] o_gpio_dir,
    output logic        o_int_n
);

    logic       scl_rise, scl_fall, start, stop, sda, byte_done, clr;
    logic [7:0] rx;

    i2c_target_bit_ctrl #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bit_ctrl (
        .clk      (i_clk),
        .reset    (i_reset),
        .scl_pad  (i_scl),
        .sda_pad  (i_sda),
        .clr      (clr),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda      (sda),
        .byte_done(byte_done),
        .rx_byte  (rx)
    );

    state_t     state, state_nx;
    logic [2:0] ptr, ptr_nx, load_ptr;
    logic       sda_oe, oe_nx;
    logic [7:0] tx, tx_nx;
    logic       rw, rw_nx;
    logic       mack, mack_nx;
    logic       wr_en, rd_load;
    logic [15:0] out_reg, pol, cfg, snap;
    logic        int_n;
    logic [16*SYNC_STAGES-1:0] gpio_pipe;
    logic [15:0] gpio_s;
    logic [7:0]  regs [0:7];

    always_ff @(posedge i_clk) begin
        gpio_pipe <= {gpio_pipe[16*(SYNC_STAGES-1)-1:0], i_gpio_in};
    end
    assign gpio_s = gpio_pipe[16*SYNC_STAGES-1 -: 16];

    always_comb begin
        regs[REG_IN0]  = gpio_s[7:0] ^ pol[7:0];
        regs[REG_IN1]  = gpio_s[15:8] ^ pol[15:8];
        regs[REG_OUT0] = out_reg[7:0];
        regs[REG_OUT1] = out_reg[15:8];
        regs[REG_POL0] = pol[7:0];
        regs[REG_POL1] = pol[15:8];
        regs[REG_CFG0] = cfg[7:0];
        regs[REG_CFG1] = cfg[15:8];
    end

    // ACK and read-data bits change on SCL fall; the master's ACK is taken on SCL rise.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        oe_nx    = sda_oe;
        tx_nx    = tx;
        rw_nx    = rw;
        mack_nx  = mack;
        clr      = 1'b0;
        wr_en    = 1'b0;
        rd_load  = 1'b0;
        load_ptr = ptr;
        if (stop) begin
            state_nx = IDLE;
            oe_nx    = 1'b0;
        end else if (start) begin
            state_nx = ADDR;
            oe_nx    = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: if (scl_fall && byte_done) begin
                    if (rx[7:1] == SADR) begin
                        state_nx = ADDR_ACK;
                        oe_nx    = 1'b1;
                        rw_nx    = rx[0];
                    end else begin
                        state_nx = IDLE;
                        oe_nx    = 1'b0;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    clr = 1'b1;
                    if (rw) begin
                        state_nx = RDATA;
                        rd_load  = 1'b1;
                    end else begin
                        state_nx = CMD;
                        oe_nx    = 1'b0;
                    end
                end
                CMD: if (scl_fall && byte_done) begin
                    state_nx = CMD_ACK;
                    oe_nx    = 1'b1;
                    ptr_nx   = rx[2:0];
                end
                CMD_ACK: if (scl_fall) begin
                    state_nx = WDATA;
                    oe_nx    = 1'b0;
                    clr      = 1'b1;
                end
                WDATA: if (scl_fall && byte_done) begin
                    state_nx = WDATA_ACK;
                    oe_nx    = 1'b1;
                    wr_en    = 1'b1;
                end
                WDATA_ACK: if (scl_fall) begin
                    state_nx = WDATA;
                    oe_nx    = 1'b0;
                    clr      = 1'b1;
                    ptr_nx   = pair_toggle(ptr);
                end
                RDATA: if (scl_fall) begin
                    if (byte_done) begin
                        state_nx = RDATA_ACK;
                        oe_nx    = 1'b0;
                    end else begin
                        tx_nx = {tx[6:0], 1'b0};
                        oe_nx = ~tx[6];
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        mack_nx = ~sda;
                    end
                    if (scl_fall) begin
                        if (mack) begin
                            state_nx = RDATA;
                            ptr_nx   = pair_toggle(ptr);
                            load_ptr = pair_toggle(ptr);
                            rd_load  = 1'b1;
                            clr      = 1'b1;
                        end else begin
                            state_nx = IDLE;
                            oe_nx    = 1'b0;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                    oe_nx    = 1'b0;
                end
            endcase
        end
        if (rd_load) begin
            tx_nx = regs[load_ptr];
            oe_nx = ~regs[load_ptr][7];
        end
    end

    always_ff @(posedge i_clk) begin
        tx   <= tx_nx;
        rw   <= rw_nx;
        mack <= mack_nx;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            out_reg <= RST_OUT;
            pol     <= RST_POL;
            cfg     <= RST_CFG;
            int_n   <= 1'b1;
            snap    <= gpio_s;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            sda_oe <= oe_nx;
            if (wr_en) begin
                case (ptr)
                    REG_OUT0: out_reg[7:0]  <= rx;
                    REG_OUT1: out_reg[15:8] <= rx;
                    REG_POL0: pol[7:0]      <= rx;
                    REG_POL1: pol[15:8]     <= rx;
                    REG_CFG0: cfg[7:0]      <= rx;
                    REG_CFG1: cfg[15:8]     <= rx;
                    default: ;
                endcase
            end
            // Reading an input port re-arms its interrupt against the sampled pins.
            if (rd_load && load_ptr == REG_IN0) snap[7:0]  <= gpio_s[7:0];
            if (rd_load && load_ptr == REG_IN1) snap[15:8] <= gpio_s[15:8];
            int_n <= ~|((gpio_s ^ snap) & cfg);
        end
    end

    assign o_sda_oe   = sda_oe;
    assign o_gpio_out = out_reg;
    assign o_gpio_dir = cfg;
    assign o_int_n    = int_n;

endmodule

// File: tb/tb_i2c_gpio_expander_target.sv
// Scoreboard bench for the I2C GPIO expander: a bus-master model queues expected
// ACK bits, read bytes and port values; a monitor process compares observations.
module tb_i2c_gpio_expander_target;

    localparam int Q = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        scl;
    logic        m_sda;
    logic        sda_bus;
    logic        sda_oe;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_dir;
    logic        int_n;
    logic        done = 1'b0;

    typedef struct {
        string       name;
        int unsigned val;
    } item_t;

    item_t exp_q[$];
    item_t obs_q[$];
    int    total  = 0;
    int    passed = 0;

    always #5 clk = ~clk;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_gpio_expander_target dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_scl     (scl),
        .i_sda     (sda_bus),
        .o_sda_oe  (sda_oe),
        .i_gpio_in (gpio_in),
        .o_gpio_out(gpio_out),
        .o_gpio_dir(gpio_dir),
        .o_int_n   (int_n)
    );

    task automatic expect_val(input string name, input int unsigned v);
        item_t it;
        it.name = name;
        it.val  = v;
        exp_q.push_back(it);
    endtask

    task automatic observe(input string name, input int unsigned v);
        item_t it;
        it.name = name;
        it.val  = v;
        obs_q.push_back(it);
    endtask

    task automatic check_port(input string name, input int unsigned exp, input int unsigned act);
        expect_val(name, exp);
        observe(name, act);
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda = b;
        wq();
        scl = 1'b1;
        wq();
        s = sda_bus;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        wq();
        scl = 1'b1;
        wq();
        m_sda = 1'b0;
        wq();
        scl = 1'b0;
        wq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        wq();
        scl = 1'b1;
        wq();
        m_sda = 1'b1;
        wq();
        wq();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic s;
        expect_val(name, exp_ack);
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        observe(name, s);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic ack, input string name);
        logic [7:0] b;
        logic       s;
        expect_val(name, exp);
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(~ack, s);
        observe(name, b);
    endtask

    task automatic compare_pending();
        item_t o;
        item_t e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL %s: got %0h, no expected value queued", o.name, o.val);
            end else begin
                e = exp_q.pop_front();
                if (e.val == o.val) passed++;
                else $display("FAIL %s: got %0h, expected %0h", e.name, o.val, e.val);
            end
        end
    endtask

    initial begin : monitor
        while (!done) begin
            @(negedge clk);
            compare_pending();
        end
        compare_pending();
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expected values never observed, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: stimulus did not complete, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic       s;
        logic [2:0] top3;
        reset   = 1'b1;
        scl     = 1'b1;
        m_sda   = 1'b1;
        gpio_in = 16'h00C0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_port("rst_oe", 0, sda_oe);
        check_port("rst_out", 16'hFFFF, gpio_out);
        check_port("rst_dir", 16'hFFFF, gpio_dir);
        check_port("rst_int", 1, int_n);

        // Output register pair reads back at reset value, pointer 2 -> 3.
        i2c_start();
        write_byte(8'h40, 1'b0, "w_addr_ack");
        write_byte(8'h02, 1'b0, "w_cmd_ack");
        i2c_stop();
        i2c_start();
        write_byte(8'h41, 1'b0, "r_addr_ack");
        read_byte(8'hFF, 1'b1, "rd_reg2_rst");
        read_byte(8'hFF, 1'b0, "rd_reg3_rst");
        i2c_stop();

        // Input read and interrupt on pin 6 change.
        i2c_start();
        write_byte(8'h40, 1'b0, "w_addr_ack");
        write_byte(8'h00, 1'b0, "w_cmd0_ack");
        i2c_start();
        write_byte(8'h41, 1'b0, "r_addr_ack");
        read_byte(8'hC0, 1'b0, "rd_in0");
        i2c_stop();
        check_port("int_idle", 1, int_n);
        gpio_in = 16'h0080;
        repeat (8) @(negedge clk);
        check_port("int_low", 0, int_n);
        i2c_start();
        write_byte(8'h41, 1'b0, "r_addr_ack");
        read_byte(8'h80, 1'b0, "rd_in0_again");
        i2c_stop();
        check_port("int_clear", 1, int_n);

        // Polarity inversion applies to input reads.
        i2c_start();
        write_byte(8'h40, 1'b0, "w_addr_ack");
        write_byte(8'h04, 1'b0, "w_cmd4_ack");
        write_byte(8'h0F, 1'b0, "w_pol0_ack");
        i2c_stop();
        i2c_start();
        write_byte(8'h40, 1'b0, "w_addr_ack");
        write_byte(8'h00, 1'b0, "w_cmd0_ack");
        i2c_start();
        write_byte(8'h41, 1'b0, "r_addr_ack");
        read_byte(8'h8F, 1'b0, "rd_in0_inv");
        i2c_stop();

        // Configuration pair write and read-back.
        i2c_start();
        write_byte(8'h40, 1'b0, "w_addr_ack");
        write_byte(8'h06, 1'b0, "w_cmd6_ack");
        write_byte(8'hEA, 1'b0, "w_cfg0_ack");
        write_byte(8'h7F, 1'b0, "w_cfg1_ack");
        i2c_stop();
        check_port("dir_write", 16'h7FEA, gpio_dir);
        i2c_start();
        write_byte(8'h40, 1'b0, "w_addr_ack");
        write_byte(8'h06, 1'b0, "w_cmd6_ack");
        i2c_start();
        write_byte(8'h41, 1'b0, "r_addr_ack");
        read_byte(8'hEA, 1'b1, "rd_cfg0");
        read_byte(8'h7F, 1'b0, "rd_cfg1");
        i2c_stop();

        // Ping-pong write across the output pair.
        i2c_start();
        write_byte(8'h40, 1'b0, "w_addr_ack");
        write_byte(8'h03, 1'b0, "w_cmd3_ack");
        write_byte(8'h11, 1'b0, "w_d11_ack");
        write_byte(8'h22, 1'b0, "w_d22_ack");
        write_byte(8'h33, 1'b0, "w_d33_ack");
        i2c_stop();
        check_port("out_pingpong", 16'h3322, gpio_out);
        i2c_start();
        write_byte(8'h40, 1'b0, "w_addr_ack");
        write_byte(8'h02, 1'b0, "w_cmd2_ack");
        i2c_start();
        write_byte(8'h41, 1'b0, "r_addr_ack");
        read_byte(8'h22, 1'b1, "rd_out0");
        read_byte(8'h33, 1'b0, "rd_out1");
        i2c_stop();

        // Foreign address is ignored for the whole transaction.
        i2c_start();
        write_byte(8'h42, 1'b1, "bad_addr_nack");
        write_byte(8'h06, 1'b1, "bad_cmd_nack");
        write_byte(8'h00, 1'b1, "bad_data_nack");
        i2c_stop();
        check_port("bad_dir", 16'h7FEA, gpio_dir);
        check_port("bad_out", 16'h3322, gpio_out);
        check_port("bad_oe", 0, sda_oe);
        check_port("int_steady", 1, int_n);

        // Reset while the target drives bit 4 of a read of 0x22.
        i2c_start();
        write_byte(8'h40, 1'b0, "w_addr_ack");
        write_byte(8'h02, 1'b0, "w_cmd2_ack");
        i2c_start();
        write_byte(8'h41, 1'b0, "r_addr_ack");
        for (int i = 2; i >= 0; i--) begin
            clk_bit(1'b1, s);
            top3[i] = s;
        end
        check_port("rd_top3", 3'b001, top3);
        m_sda = 1'b1;
        wq();
        scl = 1'b1;
        wq();
        check_port("bit4_drive", 1, sda_oe);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_port("rst_mid_oe", 0, sda_oe);
        check_port("rst_mid_out", 16'hFFFF, gpio_out);
        check_port("rst_mid_dir", 16'hFFFF, gpio_dir);
        @(negedge clk);
        reset = 1'b0;
        wq();
        wq();

        // Bus works again from the next START.
        i2c_start();
        write_byte(8'h40, 1'b0, "w_addr_ack");
        write_byte(8'h02, 1'b0, "w_cmd2_ack");
        write_byte(8'h5A, 1'b0, "w_d5a_ack");
        i2c_stop();
        check_port("out_after_rst", 16'hFF5A, gpio_out);

        repeat (4) @(negedge clk);
        done = 1'b1;
    end

endmodule
